// File: rtl/age_ordered_rs.sv
// Age-ordered multi-issue reservation station: allocates one entry per cycle, snoops the CDBs,
// and issues the oldest ready entries to the functional units that are ready.
module age_ordered_rs #(
  parameter int NUM_SLOTS    = 8,
  parameter int NUM_FU       = 4,
  parameter int NUM_CDB      = 2,
  parameter int BIT_WIDTH    = 32,
  parameter int ALU_OP_WIDTH = 7,
  parameter int TAG_WIDTH    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [TAG_WIDTH-1:0]             in_tag,
  input  logic [ALU_OP_WIDTH-1:0]          in_op,
  input  logic [TAG_WIDTH-1:0]             in_qj,
  input  logic [TAG_WIDTH-1:0]             in_qk,
  input  logic [BIT_WIDTH-1:0]             in_vj,
  input  logic [BIT_WIDTH-1:0]             in_vk,
  input  logic [NUM_CDB-1:0]               cdb_valid,
  input  logic [NUM_CDB*TAG_WIDTH-1:0]     cdb_tag,
  input  logic [NUM_CDB*BIT_WIDTH-1:0]     cdb_data,
  input  logic [NUM_FU-1:0]                fu_ready,
  output logic [NUM_FU-1:0]                issue_valid,
  output logic [NUM_FU*TAG_WIDTH-1:0]      issue_tag,
  output logic [NUM_FU*ALU_OP_WIDTH-1:0]   issue_op,
  output logic [NUM_FU*BIT_WIDTH-1:0]      issue_vj,
  output logic [NUM_FU*BIT_WIDTH-1:0]      issue_vk,
  output logic                             rs_full,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   occupancy
);
  localparam int OCC_W = $clog2(NUM_SLOTS+1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0] q;
    logic [BIT_WIDTH-1:0] v;
  } operand_t;

  // Handshakes: an allocation transfers when in_valid && in_ready at the edge (dropped on flush);
  // an issue transfers when issue_valid[k] is high at the edge, which only happens with fu_ready[k].
  logic [NUM_SLOTS-1:0]    busy;
  logic [NUM_SLOTS-1:0]    older [NUM_SLOTS];  // older[i][j]: slot j was allocated before slot i
  logic [TAG_WIDTH-1:0]    tag_q [NUM_SLOTS];
  logic [ALU_OP_WIDTH-1:0] op_q  [NUM_SLOTS];
  operand_t                opj_q [NUM_SLOTS];
  operand_t                opk_q [NUM_SLOTS];

  operand_t                opj_n [NUM_SLOTS];
  operand_t                opk_n [NUM_SLOTS];
  operand_t                in_j, in_k;
  logic [NUM_SLOTS-1:0]    ready, issued, alloc_oh;
  logic                    alloc, free_found;
  logic [OCC_W-1:0]        rank   [NUM_SLOTS];
  logic [OCC_W-1:0]        fu_pos [NUM_FU];
  logic [OCC_W-1:0]        fu_cnt;

  // Lowest-index bus wins because it is applied last; tag 0 never matches a waiting operand.
  function automatic operand_t snoop(input operand_t cur, input logic [NUM_CDB-1:0] cv,
                                     input logic [NUM_CDB*TAG_WIDTH-1:0] ct,
                                     input logic [NUM_CDB*BIT_WIDTH-1:0] cd);
    operand_t res;
    res = cur;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (cur.q != '0 && cv[c] && ct[c*TAG_WIDTH +: TAG_WIDTH] == cur.q) begin
        res.q = '0;
        res.v = cd[c*BIT_WIDTH +: BIT_WIDTH];
      end
    end
    return res;
  endfunction

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      ready[i]  = busy[i] && opj_q[i].q == '0 && opk_q[i].q == '0;
      occupancy = occupancy + OCC_W'(busy[i]);
      opj_n[i]  = snoop(opj_q[i], cdb_valid, cdb_tag, cdb_data);
      opk_n[i]  = snoop(opk_q[i], cdb_valid, cdb_tag, cdb_data);
    end
    rs_full  = &busy;
    in_ready = !rs_full;
    in_j     = snoop({in_qj, in_vj}, cdb_valid, cdb_tag, cdb_data);
    in_k     = snoop({in_qk, in_vk}, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    alloc_oh   = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!busy[i] && !free_found) begin
        alloc_oh[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
    alloc = in_valid && !rs_full && !flush;
  end

  // A ready slot's rank is the number of older ready slots; it pairs with the FU of equal position.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NUM_SLOTS; j++)
        rank[i] = rank[i] + OCC_W'(older[i][j] & ready[j]);
    end
    fu_cnt = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      fu_pos[k] = fu_cnt;
      fu_cnt    = fu_cnt + OCC_W'(fu_ready[k]);
    end
  end

  always_comb begin
    issue_valid = '0;
    issue_tag   = '0;
    issue_op    = '0;
    issue_vj    = '0;
    issue_vk    = '0;
    issued      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (fu_ready[k] && ready[i] && rank[i] == fu_pos[k]) begin
          issue_valid[k]                                  = 1'b1;
          issue_tag[k*TAG_WIDTH +: TAG_WIDTH]             = tag_q[i];
          issue_op[k*ALU_OP_WIDTH +: ALU_OP_WIDTH]        = op_q[i];
          issue_vj[k*BIT_WIDTH +: BIT_WIDTH]              = opj_q[i].v;
          issue_vk[k*BIT_WIDTH +: BIT_WIDTH]              = opk_q[i].v;
          issued[i]                                       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) older[i] <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (issued[i]) busy[i] <= 1'b0;
        if (alloc && alloc_oh[i]) begin
          busy[i]  <= 1'b1;
          older[i] <= busy;
        end else if (alloc) begin
          older[i] <= older[i] & ~alloc_oh;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (alloc && alloc_oh[i]) begin
        tag_q[i] <= in_tag;
        op_q[i]  <= in_op;
        opj_q[i] <= in_j;
        opk_q[i] <= in_k;
      end else begin
        opj_q[i] <= opj_n[i];
        opk_q[i] <= opk_n[i];
      end
    end
  end
endmodule

// File: tb/tb_age_ordered_rs.sv
// Directed bench for age_ordered_rs: each scenario task drives vectors and checks inline.
module tb_age_ordered_rs;
  localparam int NS = 8, NF = 4, NC = 2, BW = 32, OW = 7, TW = 8;

  logic             clk, reset, flush, in_valid, in_ready, rs_full;
  logic [TW-1:0]    in_tag, in_qj, in_qk;
  logic [OW-1:0]    in_op;
  logic [BW-1:0]    in_vj, in_vk;
  logic [NC-1:0]    cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NC*BW-1:0] cdb_data;
  logic [NF-1:0]    fu_ready, issue_valid;
  logic [NF*TW-1:0] issue_tag;
  logic [NF*OW-1:0] issue_op;
  logic [NF*BW-1:0] issue_vj, issue_vk;
  logic [3:0]       occupancy;

  int errors = 0;
  int checks = 0;

  age_ordered_rs #(.NUM_SLOTS(NS), .NUM_FU(NF), .NUM_CDB(NC), .BIT_WIDTH(BW),
                   .ALU_OP_WIDTH(OW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_op(in_op), .in_qj(in_qj), .in_qk(in_qk), .in_vj(in_vj), .in_vk(in_vk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .rs_full(rs_full), .occupancy(occupancy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [TW-1:0] t, input logic [OW-1:0] o, input logic [TW-1:0] qj,
                       input logic [TW-1:0] qk, input logic [BW-1:0] vj, input logic [BW-1:0] vk);
    in_valid = 1'b1; in_tag = t; in_op = o; in_qj = qj; in_qk = qk; in_vj = vj; in_vk = vk;
  endtask

  task automatic bus(input int c, input logic [TW-1:0] t, input logic [BW-1:0] d);
    cdb_valid[c] = 1'b1;
    cdb_tag[c*TW +: TW] = t;
    cdb_data[c*BW +: BW] = d;
  endtask

  task automatic quiet();
    in_valid = 1'b0;
    cdb_valid = '0;
  endtask

  function automatic logic [TW-1:0] tag_of(input int k);
    return issue_tag[k*TW +: TW];
  endfunction
  function automatic logic [OW-1:0] op_of(input int k);
    return issue_op[k*OW +: OW];
  endfunction
  function automatic logic [BW-1:0] vj_of(input int k);
    return issue_vj[k*BW +: BW];
  endfunction
  function automatic logic [BW-1:0] vk_of(input int k);
    return issue_vk[k*BW +: BW];
  endfunction

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; fu_ready = 4'b1111;
    in_valid = 1'b0; in_tag = '0; in_op = '0; in_qj = '0; in_qk = '0; in_vj = '0; in_vk = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_rs_full: got %b want 0", rs_full); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (issue_valid !== 4'b0000) begin errors++; $display("FAIL reset_issue: got %b want 0000", issue_valid); end
    reset = 1'b1;
    fu_ready = 4'b0000;
    tick();
  endtask

  task automatic test_basic();
    fu_ready = 4'b0001;
    alloc(8'd5, 7'd3, 8'd0, 8'd0, 32'd10, 32'd20);
    #1;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL basic_occ0: got %0d want 0", occupancy); end
    tick(); quiet(); #1;
    checks++; if (issue_valid !== 4'b0001) begin errors++; $display("FAIL basic_valid: got %b want 0001", issue_valid); end
    checks++; if (tag_of(0) !== 8'd5 || op_of(0) !== 7'd3) begin errors++; $display("FAIL basic_tag_op: got %0d/%0d want 5/3", tag_of(0), op_of(0)); end
    checks++; if (vj_of(0) !== 32'd10 || vk_of(0) !== 32'd20) begin errors++; $display("FAIL basic_vals: got %0d/%0d want 10/20", vj_of(0), vk_of(0)); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL basic_occ1: got %0d want 1", occupancy); end
    tick();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL basic_occ2: got %0d want 0", occupancy); end
    fu_ready = 4'b0000;
  endtask

  task automatic test_age_order();
    fu_ready = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      alloc(TW'(i), 7'd1, 8'd9, 8'd0, 32'd0, 32'(100 + i));
      tick();
    end
    quiet();
    bus(0, 8'd9, 32'd77);
    fu_ready = 4'b0110;
    #1;
    checks++; if (issue_valid !== 4'b0000) begin errors++; $display("FAIL age_no_same_cycle: got %b want 0000", issue_valid); end
    tick(); quiet(); #1;
    checks++; if (issue_valid !== 4'b0110) begin errors++; $display("FAIL age_valid: got %b want 0110", issue_valid); end
    checks++; if (tag_of(1) !== 8'd1 || tag_of(2) !== 8'd2) begin errors++; $display("FAIL age_tags: got %0d,%0d want 1,2", tag_of(1), tag_of(2)); end
    checks++; if (vj_of(1) !== 32'd77 || vj_of(2) !== 32'd77) begin errors++; $display("FAIL age_vj: got %0d,%0d want 77,77", vj_of(1), vj_of(2)); end
    tick();
    checks++; if (issue_valid !== 4'b0010 || tag_of(1) !== 8'd3) begin errors++; $display("FAIL age_third: got %b tag %0d want 0010 tag 3", issue_valid, tag_of(1)); end
    checks++; if (vj_of(1) !== 32'd77 || vk_of(1) !== 32'd103) begin errors++; $display("FAIL age_third_vals: got %0d/%0d want 77/103", vj_of(1), vk_of(1)); end
    tick();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL age_drain: got %0d want 0", occupancy); end
    fu_ready = 4'b0000;
  endtask

  task automatic test_bypass();
    fu_ready = 4'b0001;
    alloc(8'd6, 7'd2, 8'd0, 8'd4, 32'd5, 32'd0);
    bus(0, 8'd3, 32'h1111);
    bus(1, 8'd4, 32'hABCD);
    tick(); quiet(); #1;
    checks++; if (issue_valid !== 4'b0001 || tag_of(0) !== 8'd6) begin errors++; $display("FAIL bypass_issue: got %b tag %0d want 0001 tag 6", issue_valid, tag_of(0)); end
    checks++; if (vk_of(0) !== 32'hABCD || vj_of(0) !== 32'd5) begin errors++; $display("FAIL bypass_vals: got %h/%h want 5/abcd", vj_of(0), vk_of(0)); end
    tick();
    fu_ready = 4'b0000;
  endtask

  task automatic test_cdb_priority();
    fu_ready = 4'b0000;
    alloc(8'd8, 7'd1, 8'd0, 8'd0, 32'd55, 32'd66);
    bus(0, 8'd0, 32'd99);
    tick(); quiet();
    alloc(8'd7, 7'd1, 8'd12, 8'd0, 32'd0, 32'd1);
    bus(0, 8'd0, 32'd99);
    tick(); quiet();
    bus(0, 8'd12, 32'd111);
    bus(1, 8'd12, 32'd222);
    tick(); quiet();
    fu_ready = 4'b0011;
    #1;
    checks++; if (issue_valid !== 4'b0011) begin errors++; $display("FAIL prio_valid: got %b want 0011", issue_valid); end
    checks++; if (tag_of(0) !== 8'd8 || vj_of(0) !== 32'd55 || vk_of(0) !== 32'd66) begin errors++; $display("FAIL prio_tag0_ignored: got tag %0d vj %0d vk %0d want 8/55/66", tag_of(0), vj_of(0), vk_of(0)); end
    checks++; if (tag_of(1) !== 8'd7 || vj_of(1) !== 32'd111) begin errors++; $display("FAIL prio_low_bus: got tag %0d vj %0d want 7/111", tag_of(1), vj_of(1)); end
    tick();
    fu_ready = 4'b0000;
  endtask

  task automatic test_full();
    fu_ready = 4'b0000;
    for (int i = 0; i < NS; i++) begin
      alloc(TW'(10 + i), OW'(i), 8'd0, 8'd0, BW'(i), BW'(i));
      tick();
    end
    quiet(); #1;
    checks++; if (rs_full !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL full_flags: got full %b ready %b want 1/0", rs_full, in_ready); end
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ: got %0d want 8", occupancy); end
    alloc(8'd99, 7'd0, 8'd0, 8'd0, 32'd0, 32'd0);
    tick(); quiet(); #1;
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_ninth: got %0d want 8", occupancy); end
    fu_ready = 4'b0001;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_lookahead: got %b want 0", in_ready); end
    for (int i = 0; i < NS; i++) begin
      checks++;
      if (issue_valid !== 4'b0001 || tag_of(0) !== TW'(10 + i)) begin
        errors++; $display("FAIL drain_order[%0d]: got %b tag %0d want 0001 tag %0d", i, issue_valid, tag_of(0), 10 + i);
      end
      tick();
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready: got %b want 1", in_ready); end
      end
      checks++; if (occupancy !== 4'(7 - i)) begin errors++; $display("FAIL drain_occ[%0d]: got %0d want %0d", i, occupancy, 7 - i); end
    end
    fu_ready = 4'b0000;
  endtask

  task automatic test_simultaneous();
    fu_ready = 4'b0000;
    alloc(8'd20, 7'd0, 8'd0, 8'd0, 32'd0, 32'd0);  tick();
    alloc(8'd21, 7'd0, 8'd0, 8'd0, 32'd0, 32'd0);  tick();
    alloc(8'd22, 7'd0, 8'd30, 8'd0, 32'd0, 32'd0); tick();
    alloc(8'd23, 7'd0, 8'd0, 8'd0, 32'd0, 32'd0);  tick();
    alloc(8'd24, 7'd0, 8'd0, 8'd0, 32'd0, 32'd0);  tick();
    quiet(); #1;
    checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL simul_occ5: got %0d want 5", occupancy); end
    alloc(8'd25, 7'd0, 8'd0, 8'd0, 32'd0, 32'd0);
    bus(0, 8'd30, 32'd333);
    fu_ready = 4'b0011;
    #1;
    checks++; if (issue_valid !== 4'b0011 || tag_of(0) !== 8'd20 || tag_of(1) !== 8'd21) begin errors++; $display("FAIL simul_issue: got %b tags %0d,%0d want 0011 20,21", issue_valid, tag_of(0), tag_of(1)); end
    tick(); quiet(); #1;
    checks++; if (occupancy !== 4'd4) begin errors++; $display("FAIL simul_occ4: got %0d want 4", occupancy); end
    checks++; if (tag_of(0) !== 8'd22 || vj_of(0) !== 32'd333 || tag_of(1) !== 8'd23) begin errors++; $display("FAIL simul_next: got tags %0d,%0d vj %0d want 22,23 vj 333", tag_of(0), tag_of(1), vj_of(0)); end
    tick();
    checks++; if (issue_valid !== 4'b0011 || tag_of(0) !== 8'd24 || tag_of(1) !== 8'd25) begin errors++; $display("FAIL simul_last: got %b tags %0d,%0d want 0011 24,25", issue_valid, tag_of(0), tag_of(1)); end
    tick();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL simul_drain: got %0d want 0", occupancy); end
    fu_ready = 4'b0000;
  endtask

  task automatic test_flush();
    fu_ready = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      alloc(TW'(40 + i), 7'd0, 8'd0, 8'd0, 32'd0, 32'd0);
      tick();
    end
    quiet(); #1;
    checks++; if (occupancy !== 4'd6) begin errors++; $display("FAIL flush_occ6: got %0d want 6", occupancy); end
    flush = 1'b1;
    alloc(8'd50, 7'd0, 8'd0, 8'd0, 32'd0, 32'd0);
    tick(); flush = 1'b0; quiet(); #1;
    checks++; if (occupancy !== 4'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got occ %0d ready %b want 0/1", occupancy, in_ready); end
    fu_ready = 4'b1111;
    #1;
    checks++; if (issue_valid !== 4'b0000) begin errors++; $display("FAIL flush_dropped: got %b want 0000", issue_valid); end
    tick();
    fu_ready = 4'b0000;
  endtask

  task automatic test_reset_mid();
    fu_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      alloc(TW'(60 + i), 7'd0, 8'd0, 8'd0, 32'd0, 32'd0);
      tick();
    end
    quiet();
    fu_ready = 4'b0001;
    #1;
    checks++; if (issue_valid !== 4'b0001 || occupancy !== 4'd3) begin errors++; $display("FAIL rstmid_pre: got %b occ %0d want 0001 occ 3", issue_valid, occupancy); end
    reset = 1'b0;
    #2;
    checks++; if (issue_valid !== 4'b0000 || occupancy !== 4'd0) begin errors++; $display("FAIL rstmid_async: got %b occ %0d want 0000 occ 0", issue_valid, occupancy); end
    checks++; if (in_ready !== 1'b1 || rs_full !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got ready %b full %b want 1/0", in_ready, rs_full); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (issue_valid !== 4'b0000 || occupancy !== 4'd0) begin errors++; $display("FAIL rstmid_after: got %b occ %0d want 0000 occ 0", issue_valid, occupancy); end
    fu_ready = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_age_order();
    test_bypass();
    test_cdb_priority();
    test_full();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/age_ordered_rs.md
# age_ordered_rs

Parametrised, multi-issue reservation station for the Tomasulo back end. It sits between instruction decode/register-file read and a bank of `NUM_FU` functional units. It accepts one decoded instruction per cycle, snoops `NUM_CDB` common data buses for missing operands, and issues up to `NUM_FU` ready entries per cycle. Among ready entries, the oldest (allocation order) always goes first. The block also adds a pipeline flush and an occupancy count.

## Interface
Parameters:
- `NUM_SLOTS`, 8: entry count; ≥2.
- `NUM_FU`, 4: issue ports, one per functional unit; 1..`NUM_SLOTS`.
- `NUM_CDB`, 2: CDB snoop ports; ≥1.
- `BIT_WIDTH`, 32: operand width.
- `ALU_OP_WIDTH`, 7: opcode width.
- `TAG_WIDTH`, 8: producer tag width. Tag value 0 is reserved and means "operand present".

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; clears all entries.
- `in_valid` in 1: allocation request.
- `in_ready` out 1: the block can accept an allocation; equals `!rs_full`.
- `in_tag` in `TAG_WIDTH`: destination tag; must be nonzero.
- `in_op` in `ALU_OP_WIDTH`: opcode.
- `in_qj`, `in_qk` in `TAG_WIDTH` each: source producer tags; 0 means the value field is valid.
- `in_vj`, `in_vk` in `BIT_WIDTH` each: source values.
- `cdb_valid` in `NUM_CDB`: broadcast valid, one bit per bus.
- `cdb_tag` in `NUM_CDB`×`TAG_WIDTH`: broadcast tags.
- `cdb_data` in `NUM_CDB`×`BIT_WIDTH`: broadcast values.
- `fu_ready` in `NUM_FU`: functional unit can accept an operation this cycle.
- `issue_valid` out `NUM_FU`: issue to functional unit k.
- `issue_tag` out `NUM_FU`×`TAG_WIDTH`: tag of the issued operation.
- `issue_op` out `NUM_FU`×`ALU_OP_WIDTH`: opcode of the issued operation.
- `issue_vj`, `issue_vk` out `NUM_FU`×`BIT_WIDTH` each: operands of the issued operation.
- `rs_full` out 1: all slots busy.
- `occupancy` out `$clog2(NUM_SLOTS+1)`: number of busy slots.

## Operation
Per-slot state: `busy`, `tag`, `op`, `qj`, `qk`, `vj`, `vk`. An age order over busy slots is kept, for example with an age matrix.

Allocation:
- Occurs when `in_valid && in_ready && !flush` at the clock edge.
- The entry is written into the lowest-index free slot.
- The entry is youngest in the age order.

Allocation bypass:
- If `in_qj` is nonzero and matches a valid CDB tag in the same cycle, the slot stores `qj=0` and `vj` is taken from that CDB.
- The same rule applies independently to `qk`.

Wakeup:
- For each busy slot with a nonzero `qj` that equals `cdb_tag[c]` while `cdb_valid[c]` is high: store `qj=0` and `vj=cdb_data[c]`. The same rule applies to `qk`.
- Broadcasts carrying tag 0 are ignored.
- If multiple buses match, the lowest `c` wins.

Ready and issue:
- A slot is ready when it is `busy && qj==0 && qk==0`.
- Ready slots are sorted oldest first. The functional units with `fu_ready` high are taken in ascending index order.
- The i-th oldest ready slot drives the i-th ready functional unit.
- Extra ready slots wait for a later cycle.
- Extra ready functional units see `issue_valid=0`.
- `issue_valid[k]` is never asserted while `fu_ready[k]=0`. A transfer occurs whenever `issue_valid[k]` is high at the edge.
- An issued slot clears `busy` at that edge and is removed from the age order.
- The issue outputs for an FU with `issue_valid=0` are don't-care. The bench must not check them.

Flush:
- Has priority over everything else.
- At the edge: all `busy`=0 and `occupancy`=0.
- An allocation presented in the flush cycle is dropped.
- Issue outputs in the flush cycle are still driven combinationally. Functional units are required to discard them; the owning controller handles this.

Simultaneous events:
- Allocation, any number of wakeups and up to `NUM_FU` issues can all happen on the same edge.
- `occupancy` next value = current − issues + allocation.
- A slot freed by issue at edge N is allocatable from cycle N+1 only. `rs_full` does not look ahead at same-cycle issues.

Reset (`reset`=0, asynchronous):
- All `busy`=0 and the age order is cleared.
- `rs_full`=0, `in_ready`=1, `occupancy`=0, `issue_valid`=0.
- Payload registers do not need a reset.
- Reset asserted mid-operation discards every entry immediately.

## Timing
- `in_ready`, `rs_full`, `occupancy` and `issue_*` are combinational from registered slot state. `issue_valid` additionally depends on `fu_ready`.
- Nothing depends combinationally on `in_*` or `cdb_*`.
- Allocate-to-issue minimum latency: allocated at edge N with both operands present, `issue_valid` can assert in cycle N+1.
- Wakeup-to-issue: a CDB match at edge N allows issue in cycle N+1. There is no same-cycle CDB-to-issue path.
- Full throughput: one allocation per cycle and up to `NUM_FU` issues per cycle.

## Test plan
- Reset and basic issue:
  - Stimulus: release `reset`, then allocate tag 5 with op 3, `qj=qk=0`, `vj=10`, `vk=20`, with `fu_ready=4'b0001`.
  - Required: `issue_valid=4'b0001` the next cycle with tag 5, op 3, 10, 20; `occupancy` goes 0→1→0.
- Age ordering:
  - Stimulus: allocate tags 1, 2, 3, each waiting on `qj=9`. Broadcast tag 9 with data 77 on CDB0, with `fu_ready=4'b0110`.
  - Required: the next cycle FU1 gets tag 1, FU2 gets tag 2, both with `vj=77`. Tag 3 issues the following cycle.
- Allocation bypass:
  - Stimulus: allocate with `qk=4` while CDB1 broadcasts tag 4, data 0xABCD.
  - Required: the entry issues next cycle with `vk=0xABCD`.
- Full and backpressure:
  - Stimulus: hold `fu_ready=0` and fill 8 slots.
  - Required: `rs_full=1`, `in_ready=0`, `occupancy=8`. A ninth `in_valid` is ignored.
  - Then raise `fu_ready[0]`: exactly one issue per cycle, oldest first. `in_ready=1` the cycle after the first issue.
- Simultaneous events:
  - Stimulus: allocate, issue 2 entries and wake 1 entry on the same edge, starting from `occupancy=5`.
  - Required: `occupancy=4` after the edge.
- Flush and reset mid-operation:
  - Stimulus: with 6 busy slots, assert `flush` together with `in_valid`.
  - Required: `occupancy=0` next cycle and the new entry is dropped.
  - Stimulus: drop `reset` mid-cycle with 3 busy slots.
  - Required: `issue_valid=0` and `occupancy=0` immediately, without waiting for a clock edge.
